// File: rtl/spinner_pkg.sv
// Shared geometry and helpers for the spinner/dial accumulator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: default parameter values, accumulator width rule (AW = WIDTH + FRAC),
// acc_t for the default geometry, and the slow/fast step selector.
package spinner_pkg;

    localparam int WIDTH_DEF     = 4;
    localparam int FRAC_DEF      = 3;
    localparam int SLOW_STEP_DEF = 2;
    localparam int FAST_STEP_DEF = 8;
    localparam int HID_SHIFT_DEF = 0;

    // Accumulator holds the presented angle plus sub-step fraction bits below it.
    function automatic int spin_aw(input int width, input int frac);
        return width + frac;
    endfunction

    localparam int AW = WIDTH_DEF + FRAC_DEF;

    typedef logic signed [AW-1:0] acc_t;

    function automatic int unsigned step_sel(input logic        fast,
                                             input int unsigned slow_step,
                                             input int unsigned fast_step);
        return fast ? fast_step : slow_step;
    endfunction

endpackage

// File: rtl/spin_edge_det.sv
// Single-bit event detector: rising edge (TOGGLE=0) or any toggle after priming (TOGGLE=1).
// Latency: o_evt is combinational from i_sig against the value registered last cycle.
// Backpressure: none; every event is reported exactly once in the cycle it appears.
//
// Ports: clk, reset_n (async active-low), i_sig (level input synchronous to clk),
//        o_evt (one-cycle event indication).
module spin_edge_det #(
    parameter bit TOGGLE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sig,
    output logic o_evt
);

    logic r_sig_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    generate
        if (TOGGLE) begin : g_toggle
            // The first cycle out of reset only captures the current level, so a
            // toggle bit already high at release is not mistaken for a new sample.
            logic r_primed;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_primed <= 1'b0;
                end else begin
                    r_primed <= 1'b1;
                end
            end

            assign o_evt = r_primed & (i_sig ^ r_sig_d);
        end else begin : g_rise
            assign o_evt = i_sig & ~r_sig_d;
        end
    endgenerate

endmodule

// File: rtl/spinner_accum.sv
// Dial angle accumulator: joystick strobe steps and HID spinner deltas into a wrapping angle.
// Latency: event cycle N -> accumulator at edge N -> spin_out/spin_chg at edge N+1.
// Backpressure: none; one accumulate per cycle, digital and HID events merged in one add.
//
// Ports: clk, reset_n (async active-low; release expected synchronous to clk),
//        plus/minus/fast (digital direction and speed), strobe (frame tick, level),
//        spin_in[8] toggle-per-sample / spin_in[7:0] signed delta,
//        spin_out (angle, registered), spin_chg (one-cycle pulse on angle change).
// Build option: define SPIN_HID_EN to enable the HID delta path; otherwise spin_in is ignored.
import spinner_pkg::*;

module spinner_accum #(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAC      = FRAC_DEF,
    parameter int SLOW_STEP = SLOW_STEP_DEF,
    parameter int FAST_STEP = FAST_STEP_DEF,
    parameter int HID_SHIFT = HID_SHIFT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             plus,
    input  logic             minus,
    input  logic             fast,
    input  logic             strobe,
    input  logic [8:0]       spin_in,
    output logic [WIDTH-1:0] spin_out,
    output logic             spin_chg
);

    localparam int ACC_W = spin_aw(WIDTH, FRAC);

    logic             w_strobe_edge;
    logic [ACC_W-1:0] w_step;
    logic [ACC_W-1:0] w_dig_delta;
    logic [ACC_W-1:0] w_hid_delta;
    logic [ACC_W-1:0] r_acc;
    logic [WIDTH-1:0] r_spin_out;
    logic             r_spin_chg;

    // ---------------- digital path ----------------
    spin_edge_det #(.TOGGLE(1'b0)) u_strobe_det (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (strobe),
        .o_evt   (w_strobe_edge)
    );

    assign w_step = ACC_W'(step_sel(fast, SLOW_STEP, FAST_STEP));

    // Opposing directions pressed together cancel rather than favour one side.
    always_comb begin
        w_dig_delta = '0;
        if (w_strobe_edge) begin
            if (plus && !minus) begin
                w_dig_delta = w_step;
            end else if (minus && !plus) begin
                w_dig_delta = '0 - w_step;
            end
        end
    end

    // ---------------- HID path ----------------
`ifdef SPIN_HID_EN
    logic             w_hid_evt;
    logic [ACC_W-1:0] w_hid_sext;

    spin_edge_det #(.TOGGLE(1'b1)) u_hid_det (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (spin_in[8]),
        .o_evt   (w_hid_evt)
    );

    // Sign-extend (or truncate) to accumulator width; the add wraps modulo 2^ACC_W anyway.
    assign w_hid_sext  = ACC_W'(signed'(spin_in[7:0]));
    assign w_hid_delta = w_hid_evt ? (w_hid_sext << HID_SHIFT) : '0;
`else
    logic w_unused_spin_in;

    assign w_unused_spin_in = ^spin_in;
    assign w_hid_delta      = '0;
`endif

    // ---------------- accumulator and output ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= r_acc + w_dig_delta + w_hid_delta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spin_out <= '0;
            r_spin_chg <= 1'b0;
        end else begin
            r_spin_out <= r_acc[ACC_W-1:FRAC];
            r_spin_chg <= (r_acc[ACC_W-1:FRAC] != r_spin_out);
        end
    end

    assign spin_out = r_spin_out;
    assign spin_chg = r_spin_chg;

endmodule

// File: tb/tb_spinner_accum.sv
// Directed bench for spinner_accum at default geometry (WIDTH=4, FRAC=3, steps 2/8).
// Expected angles are hand-computed from the 7-bit wrapping accumulator.
// HID cases follow the SPIN_HID_EN build setting.
`timescale 1ns/1ps

module tb_spinner_accum;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       plus;
    logic       minus;
    logic       fast;
    logic       strobe;
    logic [8:0] spin_in;
    logic [3:0] spin_out;
    logic       spin_chg;

    int n_cmp   = 0;
    int n_err   = 0;
    int chg_cnt = 0;

    always #12.5 clk = ~clk;

    spinner_accum dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .plus     (plus),
        .minus    (minus),
        .fast     (fast),
        .strobe   (strobe),
        .spin_in  (spin_in),
        .spin_out (spin_out),
        .spin_chg (spin_chg)
    );

    // Count change pulses away from the active edge.
    always @(negedge clk) begin
        if (reset_n && spin_chg) chg_cnt = chg_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe high cycle, then enough cycles for spin_out and spin_chg to settle.
    task automatic pulse();
        strobe = 1'b1;
        tick(1);
        strobe = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chg_cnt = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        plus    = 1'b0;
        minus   = 1'b0;
        fast    = 1'b0;
        strobe  = 1'b0;
        spin_in = 9'h000;
        tick(3);
        chk("rst_out", spin_out, 0);
        chk("rst_chg", spin_chg, 0);
        reset_n = 1'b1;
        tick(2);
        chk("rel_out", spin_out, 0);

        // Test 1: slow steps, angle changes on the 4th edge, held strobe counts once.
        plus = 1'b1;
        repeat (3) pulse();
        chk("t1_3edges", spin_out, 0);
        chk("t1_nochg", chg_cnt, 0);
        pulse();
        chk("t1_4edges", spin_out, 1);
        chk("t1_chg_once", chg_cnt, 1);
        fast   = 1'b1;
        strobe = 1'b1;
        tick(100);
        strobe = 1'b0;
        tick(2);
        chk("t1_held", spin_out, 2);
        chk("t1_held_chg", chg_cnt, 2);

        // Latency: acc 6 -> 8 at edge N, spin_out follows at edge N+1.
        fast  = 1'b0;
        do_reset();
        repeat (3) pulse();
        strobe = 1'b1;
        tick(1);
        strobe = 1'b0;
        chk("lat_edge_n", spin_out, 0);
        tick(1);
        chk("lat_edge_n1", spin_out, 1);
        chk("lat_chg", spin_chg, 1);
        tick(1);
        chk("lat_chg_drop", spin_chg, 0);

        // Test 2: wrap down then wrap up.
        plus = 1'b0;
        do_reset();
        minus = 1'b1;
        pulse();
        chk("t2_wrap_dn", spin_out, 15);
        minus = 1'b0;
        plus  = 1'b1;
        fast  = 1'b1;
        pulse();
        chk("t2_wrap_up", spin_out, 0);
        chk("t2_chg", chg_cnt, 2);

        // Test 4a: both directions or neither leave the angle alone.
        fast = 1'b0;
        do_reset();
        repeat (4) pulse();
        minus = 1'b1;
        fast  = 1'b1;
        repeat (3) pulse();
        chk("t4_both", spin_out, 1);
        plus  = 1'b0;
        minus = 1'b0;
        repeat (2) pulse();
        chk("t4_neither", spin_out, 1);
        chk("t4_chg", chg_cnt, 1);
        fast = 1'b0;

`ifdef SPIN_HID_EN
        // Test 3: HID deltas -8 then +16 from zero.
        do_reset();
        spin_in = 9'h1F8;
        tick(3);
        chk("t3_neg", spin_out, 15);
        spin_in = 9'h010;
        tick(3);
        chk("t3_pos", spin_out, 1);
        tick(5);
        chk("t3_steady", spin_out, 1);

        // Test 4b: coincident slow edge (+2) and HID +4 from acc 2 reach 8 in one update.
        spin_in = 9'h000;
        do_reset();
        plus = 1'b1;
        pulse();
        chk("t4_base", spin_out, 0);
        spin_in = 9'h104;
        strobe  = 1'b1;
        tick(1);
        strobe  = 1'b0;
        tick(2);
        chk("t4_coinc", spin_out, 1);
        chk("t4_coinc_chg", chg_cnt, 1);
        plus = 1'b0;

        // Test 5: toggle bit high across reset release is not an event.
        spin_in = 9'h140;
        do_reset();
        tick(5);
        chk("t5_no_false", spin_out, 0);
        spin_in = 9'h040;
        tick(3);
        chk("t5_live", spin_out, 8);
        spin_in = 9'h000;
`else
        do_reset();
        spin_in = 9'h1F8;
        tick(3);
        spin_in = 9'h010;
        tick(3);
        chk("nohid_ignored", spin_out, 0);
        spin_in = 9'h140;
        tick(3);
        chk("nohid_ignored2", spin_out, 0);
        spin_in = 9'h000;
`endif

        // Test 6: reach acc 100 (12 fast + 2 slow), then asynchronous reset.
        do_reset();
        plus = 1'b1;
        fast = 1'b1;
        repeat (12) pulse();
        fast = 1'b0;
        repeat (2) pulse();
        chk("t6_pre", spin_out, 12);
        reset_n = 1'b0;
        #1;
        chk("t6_async_out", spin_out, 0);
        chk("t6_async_chg", spin_chg, 0);
        tick(2);
        plus    = 1'b0;
        reset_n = 1'b1;
        tick(2);
        chk("t6_after", spin_out, 0);
        plus = 1'b1;
        repeat (4) pulse();
        chk("t6_resume", spin_out, 1);
        plus = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
